// File: rtl/iommu_fifo_arb.sv
// Shared record queue: N requesters are arbitrated round-robin onto one
// fifo_v3, which drains through a single valid/ready port. Requester 0 keeps
// the last few slots as headroom, and a flush never overlaps a push or pop.

// Single-clock FIFO with registered read data path (no fall-through).
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      usage_q, usage_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;
  logic                  unused_testmode;

  // No scan-specific behaviour in this storage; kept for port compatibility.
  assign unused_testmode = testmode_i;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (usage_q == CNT_W'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy next-state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    usage_d  = usage_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      usage_d = usage_q + 1'b1;
      else if (do_pop && !do_push) usage_d = usage_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Storage write port.
  // NOTE: the array is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// Round-robin arbiter, headroom policy and flush sequencing around fifo_v3.
module iommu_fifo_arb #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ALM_FULL_TH = 6,
  parameter int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             testmode_i,
  input  logic [N_REQ-1:0]                 req_valid_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]                 req_ready_o,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  input  logic                             out_ready_i,
  output logic [CNT_W-1:0]                 count_o,
  output logic                             alm_full_o,
  output logic                             flushing_o
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e           state_q;
  logic             flushing_q;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, winner;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alm_full_q;
  logic [N_REQ-1:0] eligible;
  logic             found, push, pop, fifo_full, fifo_empty, idle;

  assign idle = (state_q == IDLE);

  // Eligibility mask and round-robin search starting at rr_ptr.
  always_comb begin
    int idx;
    eligible = req_valid_i;
    if (alm_full_q)       eligible = req_valid_i & N_REQ'(1);
    if (fifo_full || !idle) eligible = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = (int'(rr_ptr_q) + i) % int'(N_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
    req_ready_o = found ? (N_REQ'(1) << winner) : '0;
  end

  assign push        = |(req_valid_i & req_ready_o);
  assign out_valid_o = ~fifo_empty & idle;
  assign pop         = out_valid_o & out_ready_i;
  assign rr_ptr_d    = push ? PTR_W'((int'(winner) + 1) % int'(N_REQ)) : rr_ptr_q;

  // Fill count: cleared during FLUSH, otherwise tracks push/pop.
  always_comb begin
    count_d = count_q;
    if (!idle)               count_d = '0;
    else if (push && !pop)   count_d = count_q + 1'b1;
    else if (pop && !push)   count_d = count_q - 1'b1;
  end

  // IDLE/FLUSH sequencer with registered flushing flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      flushing_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (flush_i) begin
          state_q    <= FLUSH;
          flushing_q <= 1'b1;
        end
        FLUSH: if (!flush_i) begin
          state_q    <= IDLE;
          flushing_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          flushing_q <= 1'b0;
        end
      endcase
    end
  end

  // Arbitration pointer, fill count and almost-full flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      count_q    <= '0;
      alm_full_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      alm_full_q <= (count_d >= CNT_W'(ALM_FULL_TH));
    end
  end

  assign count_o    = count_q;
  assign alm_full_o = alm_full_q;
  assign flushing_o = flushing_q;

  fifo_v3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (!idle),
    .testmode_i (testmode_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .data_i     (req_data_i[winner]),
    .push_i     (push),
    .data_o     (out_data_o),
    .pop_i      (pop)
  );
endmodule

// File: tb/tb_iommu_fifo_arb.sv
// Directed bench for iommu_fifo_arb (N_REQ 4, DEPTH 8, ALM_FULL_TH 6).
`timescale 1ns/1ps
module tb_iommu_fifo_arb;
  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i, testmode_i, out_ready_i, out_valid_o;
  logic             alm_full_o, flushing_o;
  logic [3:0]       req_valid_i, req_ready_o;
  logic [3:0][63:0] req_data_i;
  logic [63:0]      out_data_o;
  logic [3:0]       count_o;

  int checks   = 0;
  int failures = 0;

  iommu_fifo_arb #(
    .N_REQ(4), .DATA_WIDTH(64), .DEPTH(8), .ALM_FULL_TH(6)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .testmode_i  (testmode_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .alm_full_o  (alm_full_o),
    .flushing_o  (flushing_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input logic [63:0] base);
    for (int i = 0; i < 4; i++) req_data_i[i] = base + 64'(i);
  endtask

  logic [3:0]  af_exp [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h1, 4'h1, 4'h0};
  logic [63:0] dr_exp [8] = '{64'hA1, 64'hA2, 64'hA3, 64'hA0, 64'hA1, 64'hA0, 64'hA0, 64'hA0};

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; testmode_i = 1'b0; out_ready_i = 1'b0;
    req_valid_i = 4'h0; set_data(64'hA0);
    tick(); tick();
    check("rst_count", 64'(count_o), 0);
    check("rst_out_valid", 64'(out_valid_o), 0);
    check("rst_alm_full", 64'(alm_full_o), 0);
    check("rst_flushing", 64'(flushing_o), 0);
    rst_ni = 1'b1;
    tick();

    // Round-robin with continuous drain: one push and one pop per cycle.
    out_ready_i = 1'b1; req_valid_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(req_ready_o), 64'(1) << (k % 4));
      if (k > 0) begin
        check($sformatf("rr_valid_%0d", k), 64'(out_valid_o), 1);
        check($sformatf("rr_data_%0d", k), out_data_o, 64'hA0 + 64'((k - 1) % 4));
        check($sformatf("rr_count_%0d", k), 64'(count_o), 1);
      end
      tick();
    end
    req_valid_i = 4'h0; #1;
    check("rr_last_data", out_data_o, 64'hA3);
    tick();
    check("rr_empty_count", 64'(count_o), 0);
    check("rr_empty_valid", 64'(out_valid_o), 0);

    // Lone requester 3 with rr_ptr 0; pointer wraps back to 0.
    out_ready_i = 1'b0; req_valid_i = 4'h8; #1;
    check("solo3_grant", 64'(req_ready_o), 64'h8);
    tick();
    check("solo3_count", 64'(count_o), 1);
    check("solo3_data", out_data_o, 64'hA3);
    req_valid_i = 4'hF; #1;
    check("solo3_rr_wrap", 64'(req_ready_o), 64'h1);
    req_valid_i = 4'h0; out_ready_i = 1'b1;
    tick();
    check("solo3_drained", 64'(count_o), 0);

    // Fill with no drain: headroom at 6, full at 8.
    out_ready_i = 1'b0; req_valid_i = 4'hF;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("af_count_%0d", k), 64'(count_o), 64'(k));
      check($sformatf("af_grant_%0d", k), 64'(req_ready_o), 64'(af_exp[k]));
      check($sformatf("af_alm_%0d", k), 64'(alm_full_o), 64'(k >= 6));
      if (k < 8) tick();
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0; #1;
    check("af_pop_count", 64'(count_o), 7);
    check("af_pop_grant", 64'(req_ready_o), 64'h1);
    tick();
    check("af_refill_count", 64'(count_o), 8);
    check("af_refill_grant", 64'(req_ready_o), 64'h0);
    req_valid_i = 4'h0; out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("af_drain_%0d", k), out_data_o, dr_exp[k]);
      tick();
    end
    check("af_drained", 64'(count_o), 0);

    // Simultaneous push and pop at count 3.
    out_ready_i = 1'b0; req_valid_i = 4'hF;
    tick(); tick(); tick();
    check("pp_pre_count", 64'(count_o), 3);
    set_data(64'hB0); req_valid_i = 4'h1; out_ready_i = 1'b1; #1;
    check("pp_grant", 64'(req_ready_o), 64'h1);
    tick();
    check("pp_count", 64'(count_o), 3);
    req_valid_i = 4'h0;
    check("pp_data0", out_data_o, 64'hA2);
    tick();
    check("pp_data1", out_data_o, 64'hA3);
    tick();
    check("pp_data2", out_data_o, 64'hB0);
    tick();
    check("pp_drained", 64'(count_o), 0);

    // One-cycle flush at count 5.
    out_ready_i = 1'b0; req_valid_i = 4'hF;
    repeat (5) tick();
    check("fl_pre_count", 64'(count_o), 5);
    req_valid_i = 4'h0; flush_i = 1'b1; #1;
    check("fl_pre_flushing", 64'(flushing_o), 0);
    tick();
    flush_i = 1'b0; req_valid_i = 4'hF; out_ready_i = 1'b1; #1;
    check("fl_flushing", 64'(flushing_o), 1);
    check("fl_out_valid", 64'(out_valid_o), 0);
    check("fl_grant", 64'(req_ready_o), 0);
    check("fl_count_hold", 64'(count_o), 5);
    out_ready_i = 1'b0;
    tick();
    check("fl_post_flushing", 64'(flushing_o), 0);
    check("fl_post_count", 64'(count_o), 0);
    check("fl_post_valid", 64'(out_valid_o), 0);
    check("fl_post_grant", 64'(req_ready_o), 64'h4);
    tick();
    check("fl_push_count", 64'(count_o), 1);
    check("fl_push_valid", 64'(out_valid_o), 1);
    check("fl_push_data", out_data_o, 64'hB2);

    // Asynchronous reset mid-stream at count 4.
    repeat (3) tick();
    check("rs_pre_count", 64'(count_o), 4);
    req_valid_i = 4'h0; rst_ni = 1'b0; #1;
    check("rs_count", 64'(count_o), 0);
    check("rs_out_valid", 64'(out_valid_o), 0);
    check("rs_alm_full", 64'(alm_full_o), 0);
    #1;
    rst_ni = 1'b1; req_valid_i = 4'h4; #1;
    check("rs_grant2", 64'(req_ready_o), 64'h4);
    tick();
    check("rs_count1", 64'(count_o), 1);
    check("rs_data", out_data_o, 64'hB2);
    req_valid_i = 4'hF; #1;
    check("rs_rr_ptr3", 64'(req_ready_o), 64'h8);
    req_valid_i = 4'h0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
